// File: rtl/bcd_stopwatch_if.sv
// bcd_stopwatch_if: control inputs and BCD display outputs of the stopwatch
interface bcd_stopwatch_if;
   logic       tick_in;
   logic       start_stop;
   logic       lap;
   logic       clear;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       running;
   logic       lap_active;
   logic       wrap;
   modport master (
      output tick_in, start_stop, lap, clear,
      input  sec_ones, sec_tens, min_ones, min_tens, running, lap_active, wrap
   );
   modport slave (
      input  tick_in, start_stop, lap, clear,
      output sec_ones, sec_tens, min_ones, min_tens, running, lap_active, wrap
   );
endinterface

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: MM:SS BCD stopwatch counting rising edges of a 1 Hz divider output
module bcd_stopwatch #(
   parameter int MINUTE_LIMIT = 60
) (
   input logic            clk,
   input logic            rst,
   bcd_stopwatch_if.slave sw
);
   typedef enum logic [1:0] {STOPPED, RUNNING, LAP} state_e;
   localparam logic [3:0] MT_MAX = 4'((MINUTE_LIMIT - 1) / 10);
   localparam logic [3:0] MO_MAX = 4'((MINUTE_LIMIT - 1) % 10);
   state_e      state_q, state_d;
   logic [15:0] live_q, live_d, lap_q, lap_d;
   logic        tick_prev_q, tick_prev_d, wrap_q, wrap_d;
   logic        tick_edge, inc, at_max, c0, c1, c2;
   logic [3:0]  so, st, mo, mt;
   always_comb begin
      {mt, mo, st, so} = live_q;
      tick_prev_d = sw.tick_in;
      tick_edge = sw.tick_in & ~tick_prev_q;
      inc = tick_edge & (state_q != STOPPED) & ~sw.clear;
      c0 = so == 4'd9;
      c1 = c0 && st == 4'd5;
      c2 = c1 && mo == 4'd9;
      at_max = c1 && mo == MO_MAX && mt == MT_MAX;
      wrap_d = inc & at_max;
      live_d = (sw.clear || wrap_d) ? 16'd0 : !inc ? live_q :
               {c2 ? mt + 4'd1 : mt,
                c2 ? 4'd0 : c1 ? mo + 4'd1 : mo,
                c1 ? 4'd0 : c0 ? st + 4'd1 : st,
                c0 ? 4'd0 : so + 4'd1};
      state_d = sw.clear ? STOPPED :
                sw.start_stop ? (state_q == STOPPED ? RUNNING : STOPPED) :
                (sw.lap && state_q == RUNNING) ? LAP :
                (sw.lap && state_q == LAP) ? RUNNING : state_q;
      // lap snapshot takes live_d so a same-cycle increment is included
      lap_d = sw.clear ? 16'd0 :
              (state_q == RUNNING && sw.lap && !sw.start_stop) ? live_d : lap_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= STOPPED;
         live_q      <= 16'd0;
         lap_q       <= 16'd0;
         tick_prev_q <= 1'b1;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         live_q      <= live_d;
         lap_q       <= lap_d;
         tick_prev_q <= tick_prev_d;
         wrap_q      <= wrap_d;
      end
   end
   assign {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} = state_q == LAP ? lap_q : live_q;
   assign sw.running    = state_q != STOPPED;
   assign sw.lap_active = state_q == LAP;
   assign sw.wrap       = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: two stopwatches (limits 60 and 2) checked against a seconds-count model
module tb_bcd_stopwatch;
   typedef struct {
      int   secs;
      int   lapv;
      int   st;
      logic prev;
      logic wrap;
   } mdl_t;
   logic clk = 1'b0, rst = 1'b1, tick = 1'b0, ss = 1'b0, lp = 1'b0, clr = 1'b0, go = 1'b0;
   int total = 0, bad = 0;
   mdl_t ma = '{0, 0, 0, 1'b1, 1'b0};
   mdl_t mb = '{0, 0, 0, 1'b1, 1'b0};
   always #5 clk = ~clk;
   bcd_stopwatch_if ifa ();
   bcd_stopwatch_if ifb ();
   assign ifa.tick_in = tick;
   assign ifa.start_stop = ss;
   assign ifa.lap = lp;
   assign ifa.clear = clr;
   assign ifb.tick_in = tick;
   assign ifb.start_stop = ss;
   assign ifb.lap = lp;
   assign ifb.clear = clr;
   bcd_stopwatch dut_a (.clk(clk), .rst(rst), .sw(ifa));
   bcd_stopwatch #(.MINUTE_LIMIT(2)) dut_b (.clk(clk), .rst(rst), .sw(ifb));
   wire [18:0] va = {ifa.min_tens, ifa.min_ones, ifa.sec_tens, ifa.sec_ones, ifa.running, ifa.lap_active, ifa.wrap};
   wire [18:0] vb = {ifb.min_tens, ifb.min_ones, ifb.sec_tens, ifb.sec_ones, ifb.running, ifb.lap_active, ifb.wrap};
   // st: 0 stopped, 1 running, 2 lap; count kept as plain elapsed seconds
   function automatic mdl_t step(mdl_t m, logic r, logic t, logic s, logic l, logic c, int lim);
      mdl_t n;
      n = m;
      if (r) return '{0, 0, 0, 1'b1, 1'b0};
      n.prev = t;
      n.wrap = 1'b0;
      if (c) begin
         n.secs = 0;
         n.lapv = 0;
         n.st = 0;
         return n;
      end
      if (t && !m.prev && m.st != 0) begin
         n.secs = (m.secs + 1) % (lim * 60);
         n.wrap = n.secs == 0;
      end
      if (s) n.st = m.st == 0 ? 1 : 0;
      else if (l && m.st != 0) n.st = m.st == 1 ? 2 : 1;
      if (l && !s && m.st == 1) n.lapv = n.secs;
      return n;
   endfunction
   function automatic logic [18:0] mvec(mdl_t m);
      int d, mm, sc;
      d = m.st == 2 ? m.lapv : m.secs;
      mm = d / 60;
      sc = d % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10), m.st != 0, m.st == 2, m.wrap};
   endfunction
   task automatic chk(string nm, logic [18:0] act, logic [18:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h_%b want=%h_%b", nm, act[18:3], act[2:0], exp[18:3], exp[2:0]);
      end
   endtask
   always @(posedge clk) begin
      ma <= step(ma, rst, tick, ss, lp, clr, 60);
      mb <= step(mb, rst, tick, ss, lp, clr, 2);
   end
   always @(negedge clk) if (go) begin
      chk("model_a", va, mvec(ma));
      chk("model_b", vb, mvec(mb));
   end
   task automatic lit(string nm, logic [15:0] ea, logic [2:0] fa, logic [15:0] eb, logic [2:0] fb);
      chk({nm, "_a"}, va, {ea, fa});
      chk({nm, "_b"}, vb, {eb, fb});
      chk({nm, "_ma"}, mvec(ma), {ea, fa});
      chk({nm, "_mb"}, mvec(mb), {eb, fb});
   endtask
   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic ticks(int n, int gap);
      repeat (n) begin
         tick = 1'b1;
         cyc(1);
         tick = 1'b0;
         cyc(gap - 1);
      end
   endtask
   task automatic p_ss;
      ss = 1'b1;
      cyc(1);
      ss = 1'b0;
   endtask
   task automatic p_lap;
      lp = 1'b1;
      cyc(1);
      lp = 1'b0;
   endtask
   task automatic p_clr;
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
   endtask
   initial begin
      cyc(3);
      go = 1'b1;
      lit("reset", 16'h0000, 3'b000, 16'h0000, 3'b000);
      rst = 1'b0;
      cyc(1);
      p_ss;
      lit("start", 16'h0000, 3'b100, 16'h0000, 3'b100);
      ticks(74, 8);
      lit("t74", 16'h0114, 3'b100, 16'h0114, 3'b100);
      tick = 1'b1;
      cyc(1);
      lit("t75_latency", 16'h0115, 3'b100, 16'h0115, 3'b100);
      tick = 1'b0;
      cyc(7);
      p_clr;
      lit("clear", 16'h0000, 3'b000, 16'h0000, 3'b000);
      p_ss;
      ticks(119, 4);
      lit("t119", 16'h0159, 3'b100, 16'h0159, 3'b100);
      tick = 1'b1;
      cyc(1);
      lit("wrap", 16'h0200, 3'b100, 16'h0000, 3'b101);
      tick = 1'b0;
      cyc(1);
      lit("wrap_end", 16'h0200, 3'b100, 16'h0000, 3'b100);
      cyc(2);
      ticks(1, 4);
      lit("t121", 16'h0201, 3'b100, 16'h0001, 3'b100);
      p_clr;
      p_ss;
      ticks(10, 4);
      p_lap;
      lit("lap_on", 16'h0010, 3'b110, 16'h0010, 3'b110);
      ticks(5, 4);
      lit("lap_hold", 16'h0010, 3'b110, 16'h0010, 3'b110);
      p_lap;
      lit("lap_off", 16'h0015, 3'b100, 16'h0015, 3'b100);
      p_clr;
      p_ss;
      ticks(42, 3);
      lit("t42", 16'h0042, 3'b100, 16'h0042, 3'b100);
      tick = 1'b1;
      clr = 1'b1;
      ss = 1'b1;
      cyc(1);
      tick = 1'b0;
      clr = 1'b0;
      ss = 1'b0;
      lit("clr_prio", 16'h0000, 3'b000, 16'h0000, 3'b000);
      p_ss;
      tick = 1'b1;
      cyc(20);
      lit("held_tick", 16'h0001, 3'b100, 16'h0001, 3'b100);
      tick = 1'b0;
      cyc(2);
      tick = 1'b1;
      ss = 1'b1;
      cyc(1);
      tick = 1'b0;
      ss = 1'b0;
      lit("run_tick_stop", 16'h0002, 3'b000, 16'h0002, 3'b000);
      cyc(2);
      tick = 1'b1;
      ss = 1'b1;
      cyc(1);
      tick = 1'b0;
      ss = 1'b0;
      lit("stop_tick_start", 16'h0002, 3'b100, 16'h0002, 3'b100);
      cyc(2);
      p_clr;
      p_ss;
      ticks(119, 3);
      p_lap;
      lit("lap_pre_wrap", 16'h0159, 3'b110, 16'h0159, 3'b110);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      lit("lap_wrap", 16'h0159, 3'b110, 16'h0159, 3'b111);
      cyc(2);
      p_ss;
      lit("lap_stop_live", 16'h0200, 3'b000, 16'h0000, 3'b000);
      tick = 1'b1;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(3);
      lit("rst_held_tick", 16'h0000, 3'b000, 16'h0000, 3'b000);
      p_ss;
      cyc(3);
      lit("rst_no_edge", 16'h0000, 3'b100, 16'h0000, 3'b100);
      tick = 1'b0;
      cyc(1);
      p_clr;
      p_ss;
      ticks(207, 2);
      lit("t207", 16'h0327, 3'b100, 16'h0127, 3'b100);
      tick = 1'b1;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      tick = 1'b0;
      lit("rst_mid", 16'h0000, 3'b000, 16'h0000, 3'b000);
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
